// File: rtl/gen_fre.sv
// Programmable pulse-train generator: configurable high/low times with a
// valid/ready config port applied only at period boundaries. Optional macro: GEN_FRE_RANGE_CHECK_EN.
module gen_fre #(
  parameter int unsigned W         = 16,
  parameter int unsigned HIGH_INIT = 1000,
  parameter int unsigned LOW_INIT  = 1000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         cfgValid,
  output logic         cfgReady,
  input  logic [W-1:0] cfgHigh,
  input  logic [W-1:0] cfgLow,
  output logic         bitOut,
  output logic         periodEnd,
  output logic         cfgErr,
  output logic [W-1:0] curHigh
);

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  state_t       state;
  logic [W-1:0] count;
  logic [W-1:0] act_high, act_low;
  logic [W-1:0] pend_high, pend_low;
  logic         pending;
  logic         high_last, low_last, boundary;
  logic         xfer, accept;
  logic [W-1:0] in_high, in_low;

  // Zero requests become one cycle so the period is never shorter than 2.
  assign in_high = (cfgHigh == '0) ? W'(1) : cfgHigh;
  assign in_low  = (cfgLow  == '0) ? W'(1) : cfgLow;

  assign high_last = (state == HIGH) && (count == act_high - W'(1));
  assign low_last  = (state == LOW)  && (count == act_low  - W'(1));
  assign boundary  = ((state == IDLE) && en) || low_last;
  assign xfer      = cfgValid && !pending;

`ifdef GEN_FRE_RANGE_CHECK_EN
  logic err_q;
  assign accept = xfer && (cfgHigh >= W'(831)) && (cfgHigh <= W'(1004));
  assign cfgErr = err_q;

  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= xfer && !accept;
  end
`else
  assign accept = xfer;
  assign cfgErr = 1'b0;
`endif

  assign bitOut    = (state == HIGH);
  assign periodEnd = low_last;
  assign cfgReady  = !pending;
  assign curHigh   = act_high;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      count     <= '0;
      act_high  <= W'(HIGH_INIT);
      act_low   <= W'(LOW_INIT);
      pend_high <= W'(HIGH_INIT);
      pend_low  <= W'(LOW_INIT);
      pending   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          count <= '0;
          if (en) state <= HIGH;
        end
        HIGH: begin
          if (high_last) begin
            state <= LOW;
            count <= '0;
          end else begin
            count <= count + W'(1);
          end
        end
        LOW: begin
          if (low_last) begin
            state <= en ? HIGH : IDLE;
            count <= '0;
          end else begin
            count <= count + W'(1);
          end
        end
        default: begin
          state <= IDLE;
          count <= '0;
        end
      endcase

      // A transfer needs pending==0, so it can never collide with the
      // boundary consuming an older pending value.
      if (boundary && pending) begin
        act_high <= pend_high;
        act_low  <= pend_low;
        pending  <= 1'b0;
      end
      if (accept) begin
        pend_high <= in_high;
        pend_low  <= in_low;
        pending   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_gen_fre.sv
// Self-checking bench for gen_fre: per-cycle comparison against a
// period-position model, plus run-length measurements of the waveform.
module tb_gen_fre;

  localparam int unsigned H0 = 1000;
  localparam int unsigned L0 = 1000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        cfg_valid = 1'b0;
  logic [15:0] cfg_high = '0;
  logic [15:0] cfg_low = '0;
  logic        cfg_ready, bit_out, period_end, cfg_err;
  logic [15:0] cur_high;

  int unsigned errors = 0;
  int unsigned checks = 0;

  gen_fre #(.W(16), .HIGH_INIT(H0), .LOW_INIT(L0)) dut (
    .clk(clk), .rst(rst), .en(en), .cfgValid(cfg_valid), .cfgReady(cfg_ready),
    .cfgHigh(cfg_high), .cfgLow(cfg_low), .bitOut(bit_out),
    .periodEnd(period_end), .cfgErr(cfg_err), .curHigh(cur_high)
  );

  always #5 clk = ~clk;

  logic [19:0] dut_vec;
  assign dut_vec = {bit_out, period_end, cfg_ready, cfg_err, cur_high};

  // Model: position within the current period; output is high for the
  // first m_h positions of each m_h+m_l period.
  bit          m_run, m_pend, m_err, m_xfer, m_ok, m_bnd;
  int unsigned m_pos, m_h, m_l, m_ph, m_pl;

  function automatic int unsigned clamp1(input logic [15:0] v);
    return (v == 16'd0) ? 1 : int'(v);
  endfunction

  function automatic logic [19:0] exp_vec();
    return {(m_run && m_pos < m_h), (m_run && (m_pos == m_h + m_l - 1)),
            !m_pend, m_err, 16'(m_h)};
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_run = 0; m_pos = 0; m_h = H0; m_l = L0; m_ph = H0; m_pl = L0;
      m_pend = 0; m_err = 0;
    end else begin
      m_xfer = cfg_valid && !m_pend;
`ifdef GEN_FRE_RANGE_CHECK_EN
      m_ok = (cfg_high >= 16'd831) && (cfg_high <= 16'd1004);
`else
      m_ok = 1;
`endif
      m_bnd = m_run ? (m_pos == m_h + m_l - 1) : en;
      m_err = m_xfer && !m_ok;
      if (m_bnd) begin
        if (m_pend) begin m_h = m_ph; m_l = m_pl; m_pend = 0; end
        m_run = en;
        m_pos = 0;
      end else if (m_run) begin
        m_pos++;
      end
      if (m_xfer && m_ok) begin
        m_ph = clamp1(cfg_high); m_pl = clamp1(cfg_low); m_pend = 1;
      end
    end
  end

  // Run-length measurement of the observed waveform.
  int unsigned hi_w[$], lo_w[$];
  int unsigned run_len = 0, pe_cnt = 0, err_cnt = 0;
  logic        prev_bit = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      hi_w.delete(); lo_w.delete(); run_len = 0; prev_bit = 1'b0;
    end else begin
      if (period_end === 1'b1) pe_cnt++;
      if (cfg_err === 1'b1) err_cnt++;
      if (bit_out === prev_bit) run_len++;
      else begin
        if (prev_bit) hi_w.push_back(run_len);
        else if (hi_w.size() > 0) lo_w.push_back(run_len);
        run_len = 1;
        prev_bit = bit_out;
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; cfg_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (dut_vec !== {1'b0, 1'b0, 1'b1, 1'b0, 16'(H0)}) begin
      errors++; $display("FAIL reset_state got=%h exp=%h", dut_vec, {1'b0, 1'b0, 1'b1, 1'b0, 16'(H0)});
    end
    checks++;
    if (dut_vec !== exp_vec()) begin
      errors++; $display("FAIL reset_model got=%h exp=%h", dut_vec, exp_vec());
    end
    rst = 1'b0;
  endtask

  task automatic test_defaults();
    int unsigned pe0;
    pe0 = pe_cnt;
    en = 1'b1;
    for (int i = 0; i < 4100; i++) begin
      @(negedge clk);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL defaults cyc=%0d got=%h exp=%h", i, dut_vec, exp_vec());
      end
    end
    #1;
    checks++;
    if (pe_cnt - pe0 != 2) begin
      errors++; $display("FAIL defaults_period_ends got=%0d exp=2", pe_cnt - pe0);
    end
    checks++;
    if (!(hi_w.size() >= 2 && hi_w[0] == H0 && hi_w[1] == H0 && lo_w.size() >= 1 && lo_w[0] == L0)) begin
      errors++; $display("FAIL defaults_widths got=hi%0d/lo%0d exp=%0d/%0d",
                         hi_w.size() > 0 ? hi_w[0] : 0, lo_w.size() > 0 ? lo_w[0] : 0, H0, L0);
    end
  endtask

  task automatic test_reconfig();
    bit found = 0, drop = 0;
    int unsigned stalled = 0;
    for (int i = 0; i < 4000 && !found; i++) begin
      @(negedge clk);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL reconfig_wait cyc=%0d got=%h exp=%h", i, dut_vec, exp_vec());
      end
      found = m_run && (m_pos == 500);
    end
    checks++;
    if (!found) begin errors++; $display("FAIL reconfig_sync got=timeout exp=pos500"); end
    cfg_high = 16'd900; cfg_low = 16'd100; cfg_valid = 1'b1;
    @(negedge clk);
    cfg_high = 16'd950; cfg_low = 16'd50;
    for (int i = 0; i < 3600; i++) begin
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL reconfig cyc=%0d got=%h exp=%h", i, dut_vec, exp_vec());
      end
      if (drop) cfg_valid = 1'b0;
      if (cfg_valid && !cfg_ready) stalled++;
      if (cfg_valid && cfg_ready) drop = 1;
      @(negedge clk);
    end
    #1;
    checks++;
    if (stalled < 1000) begin errors++; $display("FAIL reconfig_stall got=%0d exp>=1000", stalled); end
    checks++;
    if (cur_high !== 16'd950) begin errors++; $display("FAIL reconfig_cur got=%0d exp=950", cur_high); end
    checks++;
    if (!(hi_w.size() >= 3 && hi_w[hi_w.size()-3] == 1000 && hi_w[hi_w.size()-2] == 900 &&
          hi_w[hi_w.size()-1] == 950 && lo_w.size() >= 2 && lo_w[lo_w.size()-2] == 100 &&
          lo_w[lo_w.size()-1] == 50)) begin
      errors++; $display("FAIL reconfig_widths got=hi%0d lo%0d exp=hi950 lo50",
                         hi_w.size() > 0 ? hi_w[hi_w.size()-1] : 0, lo_w.size() > 0 ? lo_w[lo_w.size()-1] : 0);
    end
  endtask

  task automatic test_disable();
    bit found = 0;
    int unsigned pe0;
    cfg_high = 16'd900; cfg_low = 16'd100; cfg_valid = 1'b1;
    for (int i = 0; i < 3000 && !found; i++) begin
      @(negedge clk);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL disable_wait cyc=%0d got=%h exp=%h", i, dut_vec, exp_vec());
      end
      cfg_valid = 1'b0;
      found = m_run && (m_h == 900) && (m_pos == 10);
    end
    checks++;
    if (!found) begin errors++; $display("FAIL disable_sync got=timeout exp=high10"); end
    #1 pe0 = pe_cnt;
    en = 1'b0;
    for (int i = 0; i < 1200; i++) begin
      @(negedge clk);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL disable cyc=%0d got=%h exp=%h", i, dut_vec, exp_vec());
      end
    end
    #1;
    checks++;
    if (pe_cnt - pe0 != 1) begin errors++; $display("FAIL disable_period_ends got=%0d exp=1", pe_cnt - pe0); end
    checks++;
    if (bit_out !== 1'b0 || hi_w.size() == 0 || hi_w[hi_w.size()-1] != 900) begin
      errors++; $display("FAIL disable_idle got=bit%b hi%0d exp=bit0 hi900",
                         bit_out, hi_w.size() > 0 ? hi_w[hi_w.size()-1] : 0);
    end
  endtask

`ifndef GEN_FRE_RANGE_CHECK_EN
  task automatic test_zero_clamp();
    int unsigned toggles = 0;
    logic last;
    rst = 1'b1; en = 1'b0; cfg_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0; cfg_high = 16'd0; cfg_low = 16'd0; cfg_valid = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0; en = 1'b1;
    last = bit_out;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL zero_clamp cyc=%0d got=%h exp=%h", i, dut_vec, exp_vec());
      end
      if (bit_out !== last) toggles++;
      last = bit_out;
    end
    checks++;
    if (toggles < 19 || cur_high !== 16'd1) begin
      errors++; $display("FAIL zero_clamp_toggle got=%0d cur=%0d exp>=19 cur=1", toggles, cur_high);
    end
    en = 1'b0;
  endtask
`else
  task automatic test_range();
    int unsigned e0;
    rst = 1'b1; en = 1'b0; cfg_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0; en = 1'b1;
    repeat (5) @(negedge clk);
    #1 e0 = err_cnt;
    cfg_high = 16'd1005; cfg_low = 16'd1000; cfg_valid = 1'b1;
    for (int i = 0; i < 2100; i++) begin
      @(negedge clk);
      cfg_valid = 1'b0;
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL range_reject cyc=%0d got=%h exp=%h", i, dut_vec, exp_vec());
      end
    end
    #1;
    checks++;
    if (err_cnt - e0 != 1 || cur_high !== 16'd1000 || cfg_ready !== 1'b1) begin
      errors++; $display("FAIL range_reject_summary got=err%0d cur%0d exp=err1 cur1000", err_cnt - e0, cur_high);
    end
    cfg_high = 16'd831; cfg_low = 16'd100; cfg_valid = 1'b1;
    for (int i = 0; i < 2100; i++) begin
      @(negedge clk);
      cfg_valid = 1'b0;
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL range_accept cyc=%0d got=%h exp=%h", i, dut_vec, exp_vec());
      end
    end
    checks++;
    if (cur_high !== 16'd831) begin errors++; $display("FAIL range_accept_cur got=%0d exp=831", cur_high); end
    en = 1'b0;
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL random cyc=%0d got=%h exp=%h", i, dut_vec, exp_vec());
      end
      rst = ($urandom_range(0, 1499) == 0);
      en = ($urandom_range(0, 7) != 0);
      cfg_valid = ($urandom_range(0, 3) == 0);
`ifdef GEN_FRE_RANGE_CHECK_EN
      cfg_high = 16'($urandom_range(825, 1010));
      cfg_low = 16'($urandom_range(0, 40));
`else
      cfg_high = 16'($urandom_range(0, 12));
      cfg_low = 16'($urandom_range(0, 12));
`endif
    end
    rst = 1'b0; en = 1'b0; cfg_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_defaults();
    test_reconfig();
    test_disable();
`ifndef GEN_FRE_RANGE_CHECK_EN
    test_zero_clamp();
`else
    test_range();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
